// File: rtl/pulse_mod_counter.sv
//------------------------------------------------------------------------------
// Module      : pulse_mod_counter
// Description : Modulo up/down counter stepped by rising edges of an
//               asynchronous pulse, with load/clear, wrap pulse and tc flag.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pulse_mod_counter #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_pulse,
    input  logic             enable,
    input  logic             count_down,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] max_amt,
    output logic [WIDTH-1:0] cur_value,
    output logic             wrap,
    output logic             tc
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [WIDTH-1:0]       r_cur;
    logic                   r_wrap;
    logic                   w_step;
    logic [WIDTH-1:0]       w_cur_nxt;
    logic                   w_wrap_nxt;

    // Flops reset high so a pulse already high at reset release is not an edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync <= '1;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in_pulse};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_step = r_sync[SYNC_STAGES-1] & ~r_prev;

    always_comb begin
        w_cur_nxt  = r_cur;
        w_wrap_nxt = 1'b0;
        if (clear) begin
            w_cur_nxt = '0;
        end else if (load) begin
            w_cur_nxt = (load_value > max_amt) ? max_amt : load_value;
        end else if (w_step && enable) begin
            if (!count_down) begin
                if (r_cur >= max_amt) begin
                    w_cur_nxt  = '0;
                    w_wrap_nxt = 1'b1;
                end else begin
                    w_cur_nxt = r_cur + c_one;
                end
            end else if (r_cur == '0) begin
                w_cur_nxt  = max_amt;
                w_wrap_nxt = 1'b1;
            end else if (r_cur > max_amt) begin
                // Out-of-range after a modulus shrink: snap to top, no wrap.
                w_cur_nxt = max_amt;
            end else begin
                w_cur_nxt = r_cur - c_one;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cur  <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_cur  <= w_cur_nxt;
            r_wrap <= w_wrap_nxt;
        end
    end

    assign cur_value = r_cur;
    assign wrap      = r_wrap;
    assign tc        = enable & (count_down ? (r_cur == '0) : (r_cur >= max_amt));

endmodule

`default_nettype wire

// File: tb/tb_pulse_mod_counter.sv
//------------------------------------------------------------------------------
// Module      : tb_pulse_mod_counter
// Description : Scoreboard bench for pulse_mod_counter with a sampled-history
//               reference model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pulse_mod_counter;

    localparam int W = 8;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         resetn;
    logic         in_pulse;
    logic         enable;
    logic         count_down;
    logic         clear;
    logic         load;
    logic [W-1:0] load_value;
    logic [W-1:0] max_amt;
    logic [W-1:0] cur_value;
    logic         wrap;
    logic         tc;

    pulse_mod_counter #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_pulse   (in_pulse),
        .enable     (enable),
        .count_down (count_down),
        .clear      (clear),
        .load       (load),
        .load_value (load_value),
        .max_amt    (max_amt),
        .cur_value  (cur_value),
        .wrap       (wrap),
        .tc         (tc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cur;
        bit          wrap;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_wrap_seen = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: in_pulse samples per edge; a step is a 0->1 pair seen
    // S edges late, then the priority rules apply with plain arithmetic.
    initial begin : model
        bit          hist[0:S];
        bit          step;
        int unsigned m_cur = 0;
        bit          m_wrap = 0;
        int unsigned mx;
        int unsigned lv;
        forever begin
            @(posedge clk);
            if (!resetn) begin
                m_cur  = 0;
                m_wrap = 0;
                for (int i = 0; i <= S; i++) hist[i] = 1'b1;
            end else begin
                step   = hist[S-1] && !hist[S];
                mx     = max_amt;
                lv     = load_value;
                m_wrap = 0;
                if (clear) begin
                    m_cur = 0;
                end else if (load) begin
                    m_cur = (lv > mx) ? mx : lv;
                end else if (step && enable) begin
                    if (!count_down) begin
                        if (m_cur >= mx) begin m_cur = 0; m_wrap = 1; end
                        else m_cur = m_cur + 1;
                    end else begin
                        if (m_cur == 0) begin m_cur = mx; m_wrap = 1; end
                        else if (m_cur > mx) m_cur = mx;
                        else m_cur = m_cur - 1;
                    end
                end
                for (int i = S; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = in_pulse;
            end
            sb.push_back('{cur: m_cur, wrap: m_wrap});
        end
    end

    initial begin : monitor
        exp_t        e;
        int unsigned exp_tc;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 0, 1);
            end else begin
                e = sb.pop_front();
                chk("cur_value", cur_value, e.cur);
                chk("wrap", wrap, e.wrap);
                exp_tc = enable && (count_down ? (e.cur == 0) : (e.cur >= max_amt));
                chk("tc", tc, exp_tc);
                if (wrap === 1'b1) n_wrap_seen++;
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic edge_pulse(input int hi, input int lo);
        in_pulse = 1'b1;
        cyc(hi);
        in_pulse = 1'b0;
        cyc(lo);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        cyc(3);
        resetn = 1'b1;
        cyc(1);
    endtask

    task automatic do_load(input int unsigned v);
        load       = 1'b1;
        load_value = W'(v);
        cyc(1);
        load       = 1'b0;
        cyc(1);
    endtask

    initial begin : stim
        int wraps0;
        int r;
        resetn     = 1'b0;
        in_pulse   = 1'b0;
        enable     = 1'b1;
        count_down = 1'b0;
        clear      = 1'b0;
        load       = 1'b0;
        load_value = '0;
        max_amt    = 8'd5;
        cyc(1);
        chk("reset_cur", cur_value, 0);
        chk("reset_wrap", wrap, 0);
        resetn = 1'b1;
        cyc(2);

        // Up count through a wrap at max 5
        wraps0 = n_wrap_seen;
        repeat (7) edge_pulse(3, 3);
        chk("up7_cur", cur_value, 1);
        chk("up7_wraps", n_wrap_seen - wraps0, 1);

        // Down count from reset, then clamped load
        count_down = 1'b1;
        max_amt    = 8'd9;
        do_reset();
        wraps0 = n_wrap_seen;
        repeat (3) edge_pulse(3, 3);
        chk("down3_cur", cur_value, 7);
        chk("down3_wraps", n_wrap_seen - wraps0, 1);
        do_load(200);
        chk("load_clamp", cur_value, 9);

        // clear + load colliding with a synchronised step
        count_down = 1'b0;
        in_pulse   = 1'b1;
        cyc(2);
        clear      = 1'b1;
        load       = 1'b1;
        load_value = 8'd4;
        cyc(1);
        chk("clear_prio", cur_value, 0);
        clear = 1'b0;
        cyc(1);
        load     = 1'b0;
        in_pulse = 1'b0;
        cyc(3);
        chk("load_after_clear", cur_value, 4);

        // enable low drops steps; re-enable while high is not retroactive
        enable = 1'b0;
        repeat (3) edge_pulse(3, 3);
        in_pulse = 1'b1;
        cyc(3);
        enable = 1'b1;
        cyc(3);
        in_pulse = 1'b0;
        cyc(3);
        chk("enable_hold", cur_value, 4);

        // pulse high across reset release, then one wide pulse
        resetn   = 1'b0;
        in_pulse = 1'b1;
        cyc(3);
        resetn = 1'b1;
        cyc(5);
        chk("high_at_reset", cur_value, 0);
        in_pulse = 1'b0;
        cyc(3);
        edge_pulse(40, 3);
        chk("wide_pulse", cur_value, 1);

        // max_amt 0 and modulus shrink
        max_amt = 8'd0;
        wraps0  = n_wrap_seen;
        repeat (3) edge_pulse(3, 3);
        chk("max0_cur", cur_value, 0);
        chk("max0_wraps", n_wrap_seen - wraps0, 3);
        max_amt = 8'd10;
        do_load(7);
        max_amt = 8'd3;
        wraps0  = n_wrap_seen;
        edge_pulse(3, 3);
        chk("shrink_up", cur_value, 0);
        chk("shrink_up_wrap", n_wrap_seen - wraps0, 1);
        max_amt = 8'd10;
        do_load(7);
        max_amt    = 8'd3;
        count_down = 1'b1;
        wraps0     = n_wrap_seen;
        edge_pulse(3, 3);
        chk("shrink_down", cur_value, 3);
        chk("shrink_down_wrap", n_wrap_seen - wraps0, 0);

        // Randomised traffic, scoreboard-checked every cycle
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 10) max_amt = W'($urandom_range(0, 12));
            enable     = ($urandom_range(0, 9) != 0);
            count_down = 1'($urandom_range(0, 1));
            if (r >= 88 && r < 93) begin
                clear = 1'b1;
                cyc(1);
                clear = 1'b0;
            end else if (r >= 93 && r < 98) begin
                load       = 1'b1;
                load_value = W'($urandom);
                cyc(1);
                load = 1'b0;
            end else if (r == 98) begin
                resetn = 1'b0;
                cyc(2);
                resetn = 1'b1;
            end
            edge_pulse($urandom_range(1, 5), $urandom_range(1, 5));
        end

        cyc(4);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pulse_mod_counter.md
Name: pulse_mod_counter

Overview:
Parametrised modulo event counter, the successor to the fixed 4-bit pulse counter. Counts rising edges of an asynchronous pulse input inside the system clock domain. Supports up/down counting, a runtime modulus, synchronous load and clear, and emits a wrap pulse plus a terminal-count flag so instances can cascade. Used by timing and score/step logic that previously clocked counters directly off pulse signals.

Parameters:
WIDTH, 8, bit width of counter, modulus and load value (legal range 1..32)
SYNC_STAGES, 2, synchroniser flops on in_pulse (legal range 2..4)

Ports:
clk  input  1  system clock, all state on posedge
resetn  input  1  asynchronous active-low reset
in_pulse  input  1  asynchronous event input; each low->high transition is one step
enable  input  1  when low, detected steps are dropped, not queued
count_down  input  1  0 = count up, 1 = count down
clear  input  1  synchronous clear to 0
load  input  1  synchronous load of load_value
load_value  input  WIDTH  value for load
max_amt  input  WIDTH  modulus; counter range is 0..max_amt inclusive
cur_value  output  WIDTH  registered count
wrap  output  1  registered, one-cycle pulse on wrap-around
tc  output  1  combinational terminal count for cascading

Behaviour:
- Reset (resetn low, async): cur_value=0, wrap=0, all synchroniser flops and the edge-history flop = 1. A high in_pulse at reset release therefore produces no step; counting needs a low->high transition after reset.
- Synchroniser: in_pulse passes through SYNC_STAGES flops; step = sync_out & ~prev, where prev is sync_out delayed one clock.
- Latency: in_pulse first sampled high at edge N (low at N-1) -> cur_value/wrap update at edge N+SYNC_STAGES. One step per rising edge, regardless of high-pulse length.
- Minimum in_pulse high and low widths are each 2 clk periods. Shorter pulses may be lost, but never counted twice.
- Priority per clock: clear > load > (step & enable). A step in a clear or load cycle is dropped.
- clear: cur_value <= 0, wrap <= 0.
- load: cur_value <= load_value. If load_value > max_amt, cur_value <= max_amt. wrap <= 0.
- Up step: if cur_value >= max_amt then cur_value <= 0 and wrap <= 1; else cur_value <= cur_value+1.
- Down step: if cur_value == 0 then cur_value <= max_amt and wrap <= 1; else if cur_value > max_amt then cur_value <= max_amt with no wrap; else cur_value <= cur_value-1.
- wrap is 0 in every cycle without a wrapping step.
- max_amt == 0: cur_value stays 0; every accepted step asserts wrap.
- max_amt changed mid-count: takes effect on the next step. No immediate correction of cur_value.
- tc = enable & (count_down ? cur_value==0 : cur_value>=max_amt). It is combinational from registers and inputs, with no step term. Downstream cascade: next stage counts on the upstream wrap.
- Arithmetic: all compares unsigned, WIDTH bits. Increment and decrement never leave 0..max_amt except via load clamping rules above.
- enable low: the synchroniser and prev keep running, steps are discarded, cur_value holds.
- Reset asserted mid-operation: immediate return to reset values; a pending synchronised edge is lost.

Test Plan:
1. WIDTH=8, SYNC_STAGES=2, max_amt=5, up. Apply 7 in_pulse edges (high 3 clk, low 3 clk) -> cur_value 1,2,3,4,5,0,1. wrap high exactly one cycle, at the 5->0 update. Each update lands 2 clk edges after first high sample.
2. count_down=1, max_amt=9, from reset. 3 edges -> cur_value 9,8,7, with wrap only on the 0->9 step. Load 200 with max_amt=9 -> cur_value=9.
3. Priority: assert clear and load (load_value=4) in the same cycle as a synchronised step -> cur_value=0, wrap=0. Next cycle load only -> 4.
4. in_pulse held high across resetn release -> no count. Then low 3 clk, high -> exactly one count (cur_value=1). A 40-clk-wide pulse -> a single count.
5. enable=0 during 3 edges -> cur_value unchanged. Re-enable while in_pulse is high -> no retroactive count.
6. max_amt=0: 3 edges -> cur_value stays 0 and 3 wrap pulses. Then max_amt 10->3 with cur_value=7, up step -> 0 with wrap. Down step from 7 with max 3 -> 3 with no wrap.
